descrambler_rx_32b: RTL and testbench



---
 rtl/descrambler_rx_32b_if.sv | 26 ++
 rtl/descrambler_rx_32b.sv | 158 +++++++++++++++
 tb/tb_descrambler_rx_32b.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/descrambler_rx_32b_if.sv
// Bus bundle between the aligner/block-sync side and the descrambler.
// The master drives the aligned half-block and lock; the slave (descrambler)
// returns the descrambled half-block and the BER monitor status.
interface descrambler_rx_32b_if;
  logic [31:0] din;
  logic [1:0]  ctrlin;
  logic        din_en;
  logic        evenin;
  logic        block_lock;
  logic [31:0] dout;
  logic [1:0]  ctrlout;
  logic        dout_en;
  logic        evenout;
  logic        hi_ber;
  logic [4:0]  ber_cnt;

  modport master (
    output din, ctrlin, din_en, evenin, block_lock,
    input  dout, ctrlout, dout_en, evenout, hi_ber, ber_cnt
  );

  modport slave (
    input  din, ctrlin, din_en, evenin, block_lock,
    output dout, ctrlout, dout_en, evenout, hi_ber, ber_cnt
  );
endinterface

// File: rtl/descrambler_rx_32b.sv
// 10GBASE-R receive descrambler (x^58 + x^39 + 1, self-synchronizing) for a
// 32-bit half-block datapath, with a sync-header BER monitor.
// Optional feature macro: DESCRAMBLER_RX_BER_MON_EN builds the BER monitor;
// without it hi_ber and ber_cnt are tied to zero and the datapath is unchanged.
module descrambler_rx_32b
`ifdef DESCRAMBLER_RX_BER_MON_EN
  #(
    parameter int TIMER_CYCLES = 40283,
    parameter int BER_LIMIT    = 16
  )
`endif
  (
    input logic                clk,
    input logic                rst,
    descrambler_rx_32b_if.slave bus
  );

  // History holds the last 58 received (scrambled) bits; hist_q[57] is the
  // most recent one, hist_q[0] the oldest.
  logic [57:0] hist_q, hist_d;
  logic [31:0] dout_q, dout_d;
  logic [1:0]  ctrlout_q, ctrlout_d;
  logic        evenout_q, evenout_d;
  logic        dout_en_q, dout_en_d;
  logic [89:0] ext_s;
  logic [31:0] descr_s;

  // Feed-forward descramble: stream bit p = in[p] ^ in[p-39] ^ in[p-58].
  // With ext_s = {din, history}, din[n] sits at ext_s[58+n].
  always_comb begin
    ext_s     = {bus.din, hist_q};
    descr_s   = ext_s[89:58] ^ ext_s[50:19] ^ ext_s[31:0];
    hist_d    = hist_q;
    dout_d    = dout_q;
    ctrlout_d = ctrlout_q;
    evenout_d = evenout_q;
    dout_en_d = bus.din_en & bus.block_lock;
    if (bus.din_en) begin
      hist_d    = ext_s[89:32];
      dout_d    = descr_s;
      ctrlout_d = bus.ctrlin;
      evenout_d = bus.evenin;
    end else begin
      hist_d    = hist_q;
      dout_d    = dout_q;
      ctrlout_d = ctrlout_q;
      evenout_d = evenout_q;
    end
  end

  // Datapath registers; history and outputs clear asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q    <= 58'd0;
      dout_q    <= 32'd0;
      ctrlout_q <= 2'b00;
      evenout_q <= 1'b0;
      dout_en_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      dout_q    <= dout_d;
      ctrlout_q <= ctrlout_d;
      evenout_q <= evenout_d;
      dout_en_q <= dout_en_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.ctrlout = ctrlout_q;
  assign bus.evenout = evenout_q;
  assign bus.dout_en = dout_en_q;

`ifdef DESCRAMBLER_RX_BER_MON_EN
  localparam int TW = (TIMER_CYCLES > 1) ? $clog2(TIMER_CYCLES) : 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ber_state_t;

  ber_state_t    state_q;
  logic [TW-1:0] timer_q;
  logic [4:0]    ber_cnt_q;
  logic          hi_ber_q;
  logic          inv_hdr_s;
  logic          wrap_s;
  logic [4:0]    cnt_base_s;
  logic [4:0]    cnt_next_s;
  logic          hi_next_s;

  // Next window counter/flag values; a header on the wrap cycle opens the new window.
  always_comb begin
    inv_hdr_s  = bus.din_en & bus.evenin &
                 ((bus.ctrlin == 2'b00) | (bus.ctrlin == 2'b11));
    wrap_s     = (timer_q == TW'(TIMER_CYCLES - 1));
    cnt_base_s = wrap_s ? 5'd0 : ber_cnt_q;
    cnt_next_s = cnt_base_s;
    if (inv_hdr_s && (cnt_base_s < 5'(BER_LIMIT))) begin
      cnt_next_s = cnt_base_s + 5'd1;
    end else begin
      cnt_next_s = cnt_base_s;
    end
    hi_next_s = hi_ber_q;
    if (cnt_next_s == 5'(BER_LIMIT)) begin
      hi_next_s = 1'b1;
    end else if (wrap_s) begin
      hi_next_s = (ber_cnt_q >= 5'(BER_LIMIT));
    end else begin
      hi_next_s = hi_ber_q;
    end
  end

  // BER monitor FSM: idle and cleared without lock, windowed counting with lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      timer_q   <= '0;
      ber_cnt_q <= 5'd0;
      hi_ber_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          timer_q   <= '0;
          ber_cnt_q <= 5'd0;
          hi_ber_q  <= 1'b0;
          state_q   <= bus.block_lock ? ST_RUN : ST_INIT;
        end
        ST_RUN: begin
          if (!bus.block_lock) begin
            state_q   <= ST_INIT;
            timer_q   <= '0;
            ber_cnt_q <= 5'd0;
            hi_ber_q  <= 1'b0;
          end else begin
            state_q   <= ST_RUN;
            timer_q   <= wrap_s ? '0 : timer_q + TW'(1);
            ber_cnt_q <= cnt_next_s;
            hi_ber_q  <= hi_next_s;
          end
        end
        default: begin
          state_q   <= ST_INIT;
          timer_q   <= '0;
          ber_cnt_q <= 5'd0;
          hi_ber_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi_ber  = hi_ber_q;
  assign bus.ber_cnt = ber_cnt_q;
`else
  assign bus.hi_ber  = 1'b0;
  assign bus.ber_cnt = 5'd0;
`endif

endmodule

// File: tb/tb_descrambler_rx_32b.sv
// Self-checking bench for descrambler_rx_32b: impulse/gap vector table,
// scrambled round trip, async reset, BER trip/clear and lock loss.
module tb_descrambler_rx_32b;
  localparam int TIMER = 100;
  localparam int LIMIT = 16;
`ifdef DESCRAMBLER_RX_BER_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  descrambler_rx_32b_if bus();

`ifdef DESCRAMBLER_RX_BER_MON_EN
  descrambler_rx_32b #(.TIMER_CYCLES(TIMER), .BER_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`else
  descrambler_rx_32b dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [1:0]  ctrl;
    logic        en;
    logic        even;
    logic [31:0] exp_dout;
    logic [1:0]  exp_ctrl;
    logic        exp_en;
    logic        exp_even;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] c, input logic en, input logic ev);
    bus.din    = d;
    bus.ctrlin = c;
    bus.din_en = en;
    bus.evenin = ev;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"},    bus.dout, 32'd0);
    chk({tag, "_ctrlout"}, {30'd0, bus.ctrlout}, 32'd0);
    chk({tag, "_dout_en"}, {31'd0, bus.dout_en}, 32'd0);
    chk({tag, "_evenout"}, {31'd0, bus.evenout}, 32'd0);
    chk({tag, "_hi_ber"},  {31'd0, bus.hi_ber}, 32'd0);
    chk({tag, "_ber_cnt"}, {27'd0, bus.ber_cnt}, 32'd0);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].din, tbl[i].ctrl, tbl[i].en, tbl[i].even);
      tick();
      chk($sformatf("%s_dout_%0d", tag, i), bus.dout, tbl[i].exp_dout);
      chk($sformatf("%s_ctrl_%0d", tag, i), {30'd0, bus.ctrlout}, {30'd0, tbl[i].exp_ctrl});
      chk($sformatf("%s_en_%0d", tag, i), {31'd0, bus.dout_en}, {31'd0, tbl[i].exp_en});
      chk($sformatf("%s_even_%0d", tag, i), {31'd0, bus.evenout}, {31'd0, tbl[i].exp_even});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [57:0] sh;
    logic [63:0] pl;
    logic [31:0] w;
    logic [31:0] s;
    logic [1:0]  c;
    logic        y;
    int          word;

    // Impulse with gaps; gap cycles carry junk that must not be absorbed.
    tbl[0] = '{32'h0000_0001, 2'b01, 1'b1, 1'b1, 32'h0000_0001, 2'b01, 1'b1, 1'b1};
    tbl[1] = '{32'hFFFF_FFFF, 2'b11, 1'b0, 1'b0, 32'h0000_0001, 2'b01, 1'b0, 1'b1};
    tbl[2] = '{32'hFFFF_FFFF, 2'b11, 1'b0, 1'b0, 32'h0000_0001, 2'b01, 1'b0, 1'b1};
    tbl[3] = '{32'hFFFF_FFFF, 2'b11, 1'b0, 1'b0, 32'h0000_0001, 2'b01, 1'b0, 1'b1};
    tbl[4] = '{32'h0000_0000, 2'b10, 1'b1, 1'b0, 32'h0400_0080, 2'b10, 1'b1, 1'b0};
    tbl[5] = '{32'hDEAD_BEEF, 2'b00, 1'b0, 1'b1, 32'h0400_0080, 2'b10, 1'b0, 1'b0};
    tbl[6] = '{32'hDEAD_BEEF, 2'b00, 1'b0, 1'b1, 32'h0400_0080, 2'b10, 1'b0, 1'b0};
    tbl[7] = '{32'hDEAD_BEEF, 2'b00, 1'b0, 1'b1, 32'h0400_0080, 2'b10, 1'b0, 1'b0};
    tbl[8] = '{32'h0000_0000, 2'b01, 1'b1, 1'b1, 32'h0000_0000, 2'b01, 1'b1, 1'b1};

    rst = 1'b1;
    bus.block_lock = 1'b0;
    drive(32'd0, 2'b00, 1'b0, 1'b0);
    #1;
    chk_all_zero("reset");
    #2;
    rst = 1'b0;
    bus.block_lock = 1'b1;

    run_table("impulse");

    // Round trip: serial reference scrambler with a random starting state.
    sh = 58'({$urandom(), $urandom()});
    word = 0;
    for (int i = 0; i < 1000; i++) begin
      pl = {$urandom(), $urandom()};
      for (int h = 0; h < 2; h++) begin
        w = (h == 0) ? pl[31:0] : pl[63:32];
        for (int b = 0; b < 32; b++) begin
          y    = w[b] ^ sh[38] ^ sh[57];
          s[b] = y;
          sh   = {sh[56:0], y};
        end
        c = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        if ($urandom_range(0, 3) == 0) begin
          drive($urandom(), 2'b00, 1'b0, 1'b1);
          tick();
          chk("rt_gap_en", {31'd0, bus.dout_en}, 32'd0);
        end
        drive(s, c, 1'b1, (h == 0));
        tick();
        if (word >= 2) chk("rt_dout", bus.dout, w);
        chk("rt_ctrl", {30'd0, bus.ctrlout}, {30'd0, c});
        chk("rt_even", {31'd0, bus.evenout}, (h == 0) ? 32'd1 : 32'd0);
        chk("rt_en", {31'd0, bus.dout_en}, 32'd1);
        word++;
      end
    end

    // Asynchronous reset between edges, then impulse against cleared history.
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    #2;
    rst = 1'b0;
    run_table("post_rst");

    // BER monitor: restart from INIT, E0 moves to RUN with timer 0.
    tick();
    rst = 1'b1;
    bus.block_lock = 1'b0;
    #3;
    rst = 1'b0;
    drive(32'd0, 2'b01, 1'b1, 1'b1);
    bus.block_lock = 1'b1;
    tick();
    bus.ctrlin = 2'b00;
    repeat (15) tick();
    chk("ber_cnt_15", {27'd0, bus.ber_cnt}, MON ? 32'd15 : 32'd0);
    chk("hi_ber_15", {31'd0, bus.hi_ber}, 32'd0);
    tick();
    chk("ber_cnt_16", {27'd0, bus.ber_cnt}, MON ? 32'd16 : 32'd0);
    chk("hi_ber_16", {31'd0, bus.hi_ber}, MON ? 32'd1 : 32'd0);
    tick();
    chk("ber_cnt_sat", {27'd0, bus.ber_cnt}, MON ? 32'd16 : 32'd0);
    bus.ctrlin = 2'b01;
    repeat (82) tick();
    chk("hi_ber_prewrap", {31'd0, bus.hi_ber}, MON ? 32'd1 : 32'd0);
    chk("ber_cnt_prewrap", {27'd0, bus.ber_cnt}, MON ? 32'd16 : 32'd0);
    tick();
    chk("ber_cnt_wrap1", {27'd0, bus.ber_cnt}, 32'd0);
    chk("hi_ber_held", {31'd0, bus.hi_ber}, MON ? 32'd1 : 32'd0);
    repeat (99) tick();
    chk("hi_ber_prewrap2", {31'd0, bus.hi_ber}, MON ? 32'd1 : 32'd0);
    tick();
    chk("hi_ber_cleared", {31'd0, bus.hi_ber}, 32'd0);
    repeat (99) tick();
    bus.ctrlin = 2'b11;
    tick();
    chk("ber_cnt_wrap_err", {27'd0, bus.ber_cnt}, MON ? 32'd1 : 32'd0);
    chk("hi_ber_wrap_err", {31'd0, bus.hi_ber}, 32'd0);

    // Lock loss after a trip.
    bus.ctrlin = 2'b00;
    repeat (16) tick();
    chk("hi_ber_retrip", {31'd0, bus.hi_ber}, MON ? 32'd1 : 32'd0);
    bus.ctrlin = 2'b01;
    bus.block_lock = 1'b0;
    tick();
    chk("lock_loss_hi_ber", {31'd0, bus.hi_ber}, 32'd0);
    chk("lock_loss_ber_cnt", {27'd0, bus.ber_cnt}, 32'd0);
    chk("lock_loss_dout_en", {31'd0, bus.dout_en}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
